// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
//   N_DEFAULT / AW_DEFAULT : default data and address widths
//   depth()                : number of registers for a given address width
//   busy_cnt_w()           : width of a counter that must hold 0..depth
package regfile_pkg;

  localparam int N_DEFAULT  = 16;
  localparam int AW_DEFAULT = 4;

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

  // One extra bit over AW so the count can reach D itself.
  function automatic int busy_cnt_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard for the register file: one busy bit per register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   clr_i             : synchronous clear of every busy bit
//   wr_en_i/wr_addr_i : write-back, releases the destination
//   rsv_en_i/rsv_addr_i : issue-time reservation of a destination
//   busy_o            : current busy vector (pre-edge state, for reads)
//   rsv_err_o         : one-cycle pulse, reservation of a busy register refused
//   busy_cnt_o        : registered popcount of the busy vector
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW      = AW_DEFAULT,
  parameter bit R0_ZERO = 1'b0,
  localparam int D      = depth(AW),
  localparam int CW     = busy_cnt_w(AW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          rsv_en_i,
  input  logic [AW-1:0] rsv_addr_i,
  output logic [D-1:0]  busy_o,
  output logic          rsv_err_o,
  output logic [CW-1:0] busy_cnt_o
);

  logic [D-1:0]  busy_q, busy_d;
  logic          rsv_err_q, rsv_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_ok, rsv_ok;

  always_comb begin
    busy_d    = busy_q;
    rsv_err_d = 1'b0;
    wr_ok     = wr_en_i  && !(R0_ZERO && (wr_addr_i  == '0));
    rsv_ok    = rsv_en_i && !(R0_ZERO && (rsv_addr_i == '0));

    if (wr_ok) busy_d[wr_addr_i] = 1'b0;

    // A write-back to the same register in this cycle frees it first, so the
    // reservation is accepted even if the register was busy before the edge.
    if (rsv_ok) begin
      if (busy_q[rsv_addr_i] && !(wr_ok && (wr_addr_i == rsv_addr_i)))
        rsv_err_d = 1'b1;
      else
        busy_d[rsv_addr_i] = 1'b1;
    end

    if (clr_i) begin
      busy_d    = '0;
      rsv_err_d = 1'b0;
    end

    cnt_d = '0;
    for (int i = 0; i < D; i++) cnt_d = cnt_d + CW'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      rsv_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      busy_q    <= busy_d;
      rsv_err_q <= rsv_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign rsv_err_o  = rsv_err_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/scoreboard_register_file.sv
// D x N register file with one write port, two registered read ports,
// write-to-read bypass, per-register busy scoreboard and optional zero R0.
//   Clk, Rst (async, active-low), Clr (sync clear of data/busy/outputs)
//   W_data/W_addr/W_en          : write port, also releases busy[W_addr]
//   Ra_*/Rb_*                   : read ports, 1-cycle latency, 0 when disabled
//   Rsv_addr/Rsv_en             : reserve destination (mark busy)
//   Ra_busy/Rb_busy             : busy state of the read address, with data
//   Rsv_err                     : reservation of a busy register rejected
//   Busy_cnt                    : number of busy registers
module scoreboard_register_file
  import regfile_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int AW      = AW_DEFAULT,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [N-1:0]  W_data,
  input  logic [AW-1:0] W_addr,
  input  logic          W_en,
  input  logic [AW-1:0] Ra_addr,
  input  logic [AW-1:0] Rb_addr,
  input  logic          Ra_en,
  input  logic          Rb_en,
  input  logic [AW-1:0] Rsv_addr,
  input  logic          Rsv_en,
  input  logic          Clr,
  output logic [N-1:0]  Ra_data,
  output logic [N-1:0]  Rb_data,
  output logic          Ra_busy,
  output logic          Rb_busy,
  output logic          Rsv_err,
  output logic [AW:0]   Busy_cnt
);

  localparam int D = depth(AW);

  logic [N-1:0]  mem_q [D];
  logic [D-1:0]  busy_vec;
  logic          wr_ok;

  // Port 0 = A side, port 1 = B side.
  logic          rd_en   [2];
  logic [AW-1:0] rd_addr [2];
  logic [N-1:0]  rd_data_d [2], rd_data_q [2];
  logic          rd_busy_d [2], rd_busy_q [2];

  assign wr_ok      = W_en && !(R0_ZERO && (W_addr == '0));
  assign rd_en[0]   = Ra_en;
  assign rd_en[1]   = Rb_en;
  assign rd_addr[0] = Ra_addr;
  assign rd_addr[1] = Rb_addr;

  reg_scoreboard #(
    .AW      (AW),
    .R0_ZERO (R0_ZERO)
  ) u_sb (
    .clk        (Clk),
    .rst_n      (Rst),
    .clr_i      (Clr),
    .wr_en_i    (W_en),
    .wr_addr_i  (W_addr),
    .rsv_en_i   (Rsv_en),
    .rsv_addr_i (Rsv_addr),
    .busy_o     (busy_vec),
    .rsv_err_o  (Rsv_err),
    .busy_cnt_o (Busy_cnt)
  );

  // Read mux: a same-cycle write to the read address is forwarded and seen
  // in its post-write state (not busy). A hard-wired R0 always reads 0.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_d[p] = '0;
      rd_busy_d[p] = 1'b0;
      if (rd_en[p] && !(R0_ZERO && (rd_addr[p] == '0))) begin
        if (wr_ok && (W_addr == rd_addr[p])) begin
          rd_data_d[p] = W_data;
        end else begin
          rd_data_d[p] = mem_q[rd_addr[p]];
          rd_busy_d[p] = busy_vec[rd_addr[p]];
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
    end else if (Clr) begin
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[W_addr] <= W_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int p = 0; p < 2; p++) begin
        rd_data_q[p] <= '0;
        rd_busy_q[p] <= 1'b0;
      end
    end else if (Clr) begin
      for (int p = 0; p < 2; p++) begin
        rd_data_q[p] <= '0;
        rd_busy_q[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        rd_data_q[p] <= rd_data_d[p];
        rd_busy_q[p] <= rd_busy_d[p];
      end
    end
  end

  assign Ra_data = rd_data_q[0];
  assign Rb_data = rd_data_q[1];
  assign Ra_busy = rd_busy_q[0];
  assign Rb_busy = rd_busy_q[1];

endmodule

// File: tb/tb_scoreboard_register_file.sv
module tb_scoreboard_register_file;

  logic        Clk;
  logic        Rst;
  logic [15:0] W_data;
  logic [3:0]  W_addr, Ra_addr, Rb_addr, Rsv_addr;
  logic        W_en, Ra_en, Rb_en, Rsv_en, Clr;

  // Index 0: plain instance, index 1: hard-wired zero R0.
  logic [15:0] ra_d [2];
  logic [15:0] rb_d [2];
  logic        ra_b [2];
  logic        rb_b [2];
  logic        err  [2];
  logic [4:0]  cnt  [2];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state and expected registered outputs.
  logic [15:0] m_mem [2][16];
  bit          m_bsy [2][16];
  logic [15:0] e_ra [2], e_rb [2];
  bit          e_rab [2], e_rbb [2], e_err [2];
  int          e_cnt [2];

  scoreboard_register_file #(.N(16), .AW(4), .R0_ZERO(1'b0)) u0 (
    .Clk(Clk), .Rst(Rst), .W_data(W_data), .W_addr(W_addr), .W_en(W_en),
    .Ra_addr(Ra_addr), .Rb_addr(Rb_addr), .Ra_en(Ra_en), .Rb_en(Rb_en),
    .Rsv_addr(Rsv_addr), .Rsv_en(Rsv_en), .Clr(Clr),
    .Ra_data(ra_d[0]), .Rb_data(rb_d[0]), .Ra_busy(ra_b[0]), .Rb_busy(rb_b[0]),
    .Rsv_err(err[0]), .Busy_cnt(cnt[0])
  );

  scoreboard_register_file #(.N(16), .AW(4), .R0_ZERO(1'b1)) u1 (
    .Clk(Clk), .Rst(Rst), .W_data(W_data), .W_addr(W_addr), .W_en(W_en),
    .Ra_addr(Ra_addr), .Rb_addr(Rb_addr), .Ra_en(Ra_en), .Rb_en(Rb_en),
    .Rsv_addr(Rsv_addr), .Rsv_en(Rsv_en), .Clr(Clr),
    .Ra_data(ra_d[1]), .Rb_data(rb_d[1]), .Ra_busy(ra_b[1]), .Rb_busy(rb_b[1]),
    .Rsv_err(err[1]), .Busy_cnt(cnt[1])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 16; r++) begin
        m_mem[k][r] = '0;
        m_bsy[k][r] = 0;
      end
      e_ra[k] = '0; e_rb[k] = '0; e_rab[k] = 0; e_rbb[k] = 0;
      e_err[k] = 0; e_cnt[k] = 0;
    end
  endtask

  // What a register looks like to a reader this cycle, following the rules:
  // disabled -> 0; zero R0 -> 0; same-cycle write -> new data, not busy.
  task automatic model_read(input int k, input bit en, input logic [3:0] a,
                            output logic [15:0] d, output bit b);
    d = '0; b = 0;
    if (en && !(k == 1 && a == 0)) begin
      if (W_en && W_addr == a) d = W_data;
      else begin d = m_mem[k][a]; b = m_bsy[k][a]; end
    end
  endtask

  // Applies one rising edge to the model using the inputs present now.
  task automatic model_edge();
    bit wr, rsv, rej;
    if (!Rst || Clr) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      model_read(k, Ra_en, Ra_addr, e_ra[k], e_rab[k]);
      model_read(k, Rb_en, Rb_addr, e_rb[k], e_rbb[k]);
      wr  = W_en   && !(k == 1 && W_addr == 0);
      rsv = Rsv_en && !(k == 1 && Rsv_addr == 0);
      rej = rsv && m_bsy[k][Rsv_addr] && !(wr && W_addr == Rsv_addr);
      if (wr) begin
        m_mem[k][W_addr] = W_data;
        m_bsy[k][W_addr] = 0;
      end
      if (rsv && !rej) m_bsy[k][Rsv_addr] = 1;
      e_err[k] = rej;
      e_cnt[k] = 0;
      for (int r = 0; r < 16; r++) e_cnt[k] += int'(m_bsy[k][r]);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.Ra_data", k),  32'(ra_d[k]), 32'(e_ra[k]));
      chk($sformatf("u%0d.Rb_data", k),  32'(rb_d[k]), 32'(e_rb[k]));
      chk($sformatf("u%0d.Ra_busy", k),  32'(ra_b[k]), 32'(e_rab[k]));
      chk($sformatf("u%0d.Rb_busy", k),  32'(rb_b[k]), 32'(e_rbb[k]));
      chk($sformatf("u%0d.Rsv_err", k),  32'(err[k]),  32'(e_err[k]));
      chk($sformatf("u%0d.Busy_cnt", k), 32'(cnt[k]),  32'(e_cnt[k]));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    W_en = 0; Ra_en = 0; Rb_en = 0; Rsv_en = 0; Clr = 0;
  endtask

  initial begin
    Rst = 0; idle();
    W_data = '0; W_addr = '0; Ra_addr = '0; Rb_addr = '0; Rsv_addr = '0;
    model_reset();

    // Reset held for two edges.
    tick(); tick();
    Rst = 1;

    // Load reg I = I + 0x10.
    for (int i = 0; i < 16; i++) begin
      W_en = 1; W_addr = 4'(i); W_data = 16'(i + 16'h10);
      tick();
    end
    idle();

    // Read back A=I, B=(I+8)%16.
    for (int i = 0; i < 16; i++) begin
      Ra_en = 1; Ra_addr = 4'(i);
      Rb_en = 1; Rb_addr = 4'((i + 8) % 16);
      tick();
      if (i != 0) chk("load.ra", 32'(ra_d[0]), 32'(i + 16'h10));
      chk("load.rb", 32'(rb_d[0]), 32'(((i + 8) % 16) + 16'h10));
    end
    idle(); tick();
    chk("disabled.ra", 32'(ra_d[0]), 32'h0);

    // Bypass.
    W_en = 1; W_addr = 5; W_data = 16'h0015; tick();
    W_data = 16'hBEEF; Ra_en = 1; Ra_addr = 5; tick();
    chk("bypass.ra", 32'(ra_d[0]), 32'hBEEF);
    chk("bypass.busy", 32'(ra_b[0]), 32'h0);
    idle();

    // Scoreboard: reserve, hazard read, double reserve, write-back.
    Rsv_en = 1; Rsv_addr = 3; tick();
    chk("rsv.cnt1", 32'(cnt[0]), 32'd1);
    Rsv_en = 0; Ra_en = 1; Ra_addr = 3; tick();
    chk("rsv.busy", 32'(ra_b[0]), 32'd1);
    Ra_en = 0; Rsv_en = 1; tick();
    chk("rsv.err", 32'(err[0]), 32'd1);
    chk("rsv.cnt_hold", 32'(cnt[0]), 32'd1);
    Rsv_en = 0; W_en = 1; W_addr = 3; W_data = 16'h0033; tick();
    chk("rsv.err_pulse", 32'(err[0]), 32'd0);
    chk("wb.cnt0", 32'(cnt[0]), 32'd0);
    W_en = 0; Ra_en = 1; tick();
    chk("wb.ra", 32'(ra_d[0]), 32'h0033);
    idle();

    // Same-cycle write and reserve of register 7.
    W_en = 1; W_addr = 7; W_data = 16'h0777; Rsv_en = 1; Rsv_addr = 7; tick();
    chk("wr_rsv.cnt", 32'(cnt[0]), 32'd1);
    chk("wr_rsv.err", 32'(err[0]), 32'd0);
    idle(); Ra_en = 1; Ra_addr = 7; tick();
    chk("wr_rsv.ra", 32'(ra_d[0]), 32'h0777);
    chk("wr_rsv.busy", 32'(ra_b[0]), 32'd1);
    // Write and reserve again while busy: accepted, no error.
    idle(); W_en = 1; W_addr = 7; W_data = 16'h0778; Rsv_en = 1; Rsv_addr = 7; tick();
    chk("wr_rsv_busy.err", 32'(err[0]), 32'd0);
    idle();

    // Zero register.
    W_en = 1; W_addr = 0; W_data = 16'hFFFF; Rsv_en = 1; Rsv_addr = 0; tick();
    idle(); Ra_en = 1; Ra_addr = 0; tick();
    chk("r0.ra", 32'(ra_d[1]), 32'h0);
    chk("r0.busy", 32'(ra_b[1]), 32'h0);
    chk("r0.cnt", 32'(cnt[1]), 32'd1);
    chk("r0.err", 32'(err[1]), 32'd0);
    idle();

    // Clear.
    for (int i = 0; i < 3; i++) begin
      Rsv_en = 1; Rsv_addr = 4'(1 << i);
      W_en = 1; W_addr = 4'(8 + i); W_data = 16'(16'hA000 + i);
      tick();
    end
    idle(); Clr = 1; Ra_en = 1; Ra_addr = 9; W_en = 1; W_addr = 9; Rsv_en = 1; Rsv_addr = 9;
    tick();
    chk("clr.cnt", 32'(cnt[0]), 32'd0);
    chk("clr.ra", 32'(ra_d[0]), 32'h0);
    idle(); Ra_en = 1; Ra_addr = 8; Rb_en = 1; Rb_addr = 1; tick();
    idle();

    // Refill, then asynchronous reset between edges.
    for (int i = 0; i < 4; i++) begin
      W_en = 1; W_addr = 4'(i + 2); W_data = 16'(16'h5500 + i);
      Rsv_en = 1; Rsv_addr = 4'(i + 10); Ra_en = 1; Ra_addr = 4'(i + 1);
      Rb_en = 1; Rb_addr = 4'(i + 10);
      tick();
    end
    #2 Rst = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst.u%0d.ra", k),  32'(ra_d[k]), 32'h0);
      chk($sformatf("arst.u%0d.rb", k),  32'(rb_d[k]), 32'h0);
      chk($sformatf("arst.u%0d.rab", k), 32'(ra_b[k]), 32'h0);
      chk($sformatf("arst.u%0d.rbb", k), 32'(rb_b[k]), 32'h0);
      chk($sformatf("arst.u%0d.cnt", k), 32'(cnt[k]),  32'h0);
      chk($sformatf("arst.u%0d.err", k), 32'(err[k]),  32'h0);
    end
    model_reset();
    tick();
    Rst = 1;
    idle(); Ra_en = 1; Ra_addr = 2; Rb_en = 1; Rb_addr = 10; tick();
    chk("post_rst.ra", 32'(ra_d[0]), 32'h0);
    chk("post_rst.rbb", 32'(rb_b[0]), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      W_en     = ($urandom_range(0, 9) < 4);
      W_addr   = 4'($urandom_range(0, 15));
      W_data   = 16'($urandom);
      Rsv_en   = ($urandom_range(0, 9) < 6);
      Rsv_addr = 4'($urandom_range(0, 15));
      Ra_en    = ($urandom_range(0, 3) != 0);
      Rb_en    = ($urandom_range(0, 3) != 0);
      Ra_addr  = ($urandom_range(0, 3) == 0) ? W_addr : 4'($urandom_range(0, 15));
      Rb_addr  = ($urandom_range(0, 3) == 0) ? Ra_addr : 4'($urandom_range(0, 15));
      Clr      = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
